i2c_cmd_sequencer: RTL

Command queue and issue engine sitting directly upstream of `i2c_master`. Buffers host write/read transactions (chip address, register address, 16-bit data) in a FIFO, drives them one at a time into the master's enable/address/data inputs, and waits for the master to go idle. Returns one response per command, carrying read data and master status, through a valid/ready port. Host logic no longer has to pulse the master enables or poll `busy` by hand.

---
 rtl/i2c_cmd_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_cmd_sequencer.sv
// Command FIFO and one-at-a-time issue engine in front of i2c_master, with a valid/ready response port.
// Optional busy-wait timeout is compiled in when I2C_SEQ_TIMEOUT_EN is defined.
module i2c_cmd_sequencer #(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    reset,
    // host command port
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_rw,
    input  logic [6:0]              cmd_chip_addr,
    input  logic [7:0]              cmd_reg_addr,
    input  logic [15:0]             cmd_data,
    // host response port
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_rw,
    output logic [15:0]             rsp_data,
    output logic [3:0]              rsp_status,
    output logic                    rsp_err,
    // i2c_master side
    output logic [6:0]              m_chip_addr,
    output logic [7:0]              m_reg_addr,
    output logic [15:0]             m_data_in,
    output logic                    m_write_en,
    output logic                    m_read_en,
    input  logic                    m_busy,
    input  logic [3:0]              m_status,
    input  logic [15:0]             m_data_out,
    // status
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    idle
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [2:0] {StIdle, StIssue, StGap, StWait, StResp} state_e;

    state_e         state_q;
    logic [31:0]    mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW:0]    count_q;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic [31:0]    head;
    logic           rw_q;
    logic [3:0]     cap_status_q;
    logic [15:0]    cap_data_q;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]  to_cnt_q;
    logic           cap_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign full       = (count_q == (AW + 1)'(DEPTH));
    assign empty      = (count_q == '0);
    assign cmd_ready  = !full;
    assign push       = cmd_valid && !full;
    assign pop        = (state_q == StIdle) && !empty && !m_busy;
    assign head       = mem_q[rd_ptr_q];
    assign fifo_count = count_q;
    assign idle       = (state_q == StIdle) && empty && !rsp_valid;

    // Storage needs no reset: the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_rw, cmd_chip_addr, cmd_reg_addr, cmd_data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            rw_q         <= 1'b0;
            m_chip_addr  <= '0;
            m_reg_addr   <= '0;
            m_data_in    <= '0;
            m_write_en   <= 1'b0;
            m_read_en    <= 1'b0;
            cap_status_q <= '0;
            cap_data_q   <= '0;
            rsp_valid    <= 1'b0;
            rsp_rw       <= 1'b0;
            rsp_data     <= '0;
            rsp_status   <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
            rsp_err      <= 1'b0;
            cap_err_q    <= 1'b0;
            to_cnt_q     <= '0;
`endif
        end else begin
            // Consumed response drops here unless StResp reloads it below.
            if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        rw_q        <= head[31];
                        m_chip_addr <= head[30:24];
                        m_reg_addr  <= head[23:16];
                        m_data_in   <= head[15:0];
                        m_write_en  <= !head[31];
                        m_read_en   <= head[31];
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    m_write_en <= 1'b0;
                    m_read_en  <= 1'b0;
                    state_q    <= StGap;
                end
                StGap: begin
`ifdef I2C_SEQ_TIMEOUT_EN
                    to_cnt_q <= '0;
`endif
                    state_q  <= StWait;
                end
                StWait: begin
                    if (!m_busy) begin
                        cap_status_q <= m_status;
                        cap_data_q   <= rw_q ? m_data_out : 16'h0000;
`ifdef I2C_SEQ_TIMEOUT_EN
                        cap_err_q    <= 1'b0;
`endif
                        state_q      <= StResp;
                    end
`ifdef I2C_SEQ_TIMEOUT_EN
                    else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        cap_status_q <= m_status;
                        cap_data_q   <= 16'h0000;
                        cap_err_q    <= 1'b1;
                        state_q      <= StResp;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
`endif
                end
                StResp: begin
                    if (!rsp_valid || rsp_ready) begin
                        rsp_valid  <= 1'b1;
                        rsp_rw     <= rw_q;
                        rsp_data   <= cap_data_q;
                        rsp_status <= cap_status_q;
`ifdef I2C_SEQ_TIMEOUT_EN
                        rsp_err    <= cap_err_q;
`endif
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
